fetch_unit_wide: RTL and testbench
==================================

// Module: fetch_unit_wide
// PURPOSE
// - Parametrised successor fetch front end for the OoO core: fetches FETCH_WIDTH-instruction aligned blocks from imem.
// - Masks slots before the PC offset and compacts the survivors into a multi-ported instruction queue (IQ).
// - Presents up to FETCH_WIDTH in-order instructions per cycle to dispatch.
// - Handles redirects (mispredict/flush) at any point, including while a request is in flight.
// PARAMETERS
// - FETCH_WIDTH  2            instructions per fetch block/dispatch group; power of 2, >=1
// - IQ_DEPTH     8            IQ entries; power of 2, multiple of FETCH_WIDTH, >=2*FETCH_WIDTH
// - RESET_PC     32'h1eceb000 first fetch address after reset
// PORTS
// - clk            in   1                clock
// - rst            in   1                synchronous active-high reset
// - redirect_valid in   1                flush IQ, restart fetch at redirect_pc
// - redirect_pc    in   32               new PC, 4-byte aligned
// - imem_addr      out  32               block address = fetch_pc & ~(FETCH_WIDTH*4-1)
// - imem_rmask     out  4                4'hF while a request is outstanding, else 0
// - imem_resp      in   1                response valid; completes the outstanding request
// - imem_rdata     in   FETCH_WIDTH*32   slot i = bits [32i+31:32i] = inst at imem_addr+4i
// - out_valid      out  FETCH_WIDTH      out_valid[i]: IQ entry head+i present; thermometer coded (LSBs first)
// - out_inst       out  FETCH_WIDTH*32   instruction of IQ entry head+i
// - out_pc         out  FETCH_WIDTH*32   PC of IQ entry head+i
// - deq_count      in   $clog2(FW)+1     entries consumed this cycle by dispatch; <= popcount(out_valid)
// BEHAVIOUR
// - Reset: state=IDLE, fetch_pc=RESET_PC, IQ empty, imem_rmask=0, out_valid=0.
// - FSM states:
//   - IDLE: no request.
//   - WAIT: request outstanding, data wanted.
//   - DISCARD: request outstanding, data dropped.
// - imem_addr and imem_rmask are held stable from issue until the imem_resp cycle (resp may arrive same cycle).
// - IDLE->WAIT when free >= FETCH_WIDTH and no redirect; free = IQ_DEPTH - count after this cycle's dequeue.
// - WAIT + imem_resp, no redirect:
//   - enqueue slots k = fetch_pc[log2(FW)+1:2] .. FW-1, compacted into consecutive entries; pc = block + 4k.
//   - fetch_pc <= block + FETCH_WIDTH*4.
//   - stay WAIT (back-to-back) if free after the enqueue is >= FETCH_WIDTH, else go IDLE.
// - Redirect, any state: IQ flushed (count=0, ptrs=0), deq_count ignored, fetch_pc <= redirect_pc.
//   - IDLE: next state WAIT.
//   - WAIT/DISCARD with no resp this cycle: next state DISCARD.
//   - WAIT/DISCARD with resp the same cycle: data dropped, next state WAIT.
// - DISCARD + imem_resp: data dropped, next state WAIT at fetch_pc; redirects while in DISCARD overwrite fetch_pc.
// - IQ: circular buffer, log2(IQ_DEPTH)-bit pointers with natural wrap, count width $clog2(IQ_DEPTH+1).
//   - Up to FW enqueues and FW dequeues per cycle; simultaneous enq+deq allowed.
//   - Never overflows: a request is only issued with >= FW free entries.
// - Latency: response cycle N -> entries visible on out_* at cycle N+1; outputs driven combinationally from the IQ head.
// - out_valid[i] = (i < count). Unused out_inst/out_pc lanes are don't-care.
// - deq_count > popcount(out_valid) is illegal; assert in simulation.
// TESTING
// - Reset then imem_resp 1 cycle after request:
//   - imem_addr=1eceb000 with rmask F.
//   - next cycle out_valid=2'b11, out_pc={1eceb004,1eceb000}.
// - Redirect to 1eceb014 (FW=2):
//   - imem_addr=1eceb010.
//   - only slot1 enqueued; out_valid=2'b01, out_pc[0]=1eceb014.
//   - next request at 1eceb018.
// - Redirect while WAIT, resp 3 cycles later:
//   - rdata dropped, IQ stays empty.
//   - next request at redirect block; no stale entry ever appears.
// - deq_count=0 for many cycles:
//   - IQ fills to 8.
//   - rmask drops to 0 once free<2 and no overflow; fetch resumes after deq_count=2.
// - Redirect and imem_resp in the same cycle:
//   - response dropped.
//   - the following cycle issues imem_addr=redirect block in WAIT.
// - Pointer wrap: stream 20 blocks with deq_count alternating 1/2 -> out_pc strictly +4 sequential across the wrap.

Source files
------------

// File: rtl/fetch_unit_wide.sv
// fetch_unit_wide: wide fetch front end that fetches aligned FETCH_WIDTH-instruction
// blocks from imem, drops slots before the PC offset, compacts the survivors into a
// circular instruction queue and presents up to FETCH_WIDTH in-order entries to dispatch.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   redirect_valid/_pc       flush the queue and restart fetch at redirect_pc
//   imem_addr/imem_rmask     block request, held stable while outstanding
//   imem_resp/imem_rdata     response strobe and block data (slot i at bits 32i+:32)
//   out_valid/inst/pc        queue head window, thermometer-coded valid
//   deq_count                entries taken by dispatch this cycle
module fetch_unit_wide #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          IQ_DEPTH    = 8,
    parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic [31:0]                   imem_addr,
    output logic [3:0]                    imem_rmask,
    input  logic                          imem_resp,
    input  logic [FETCH_WIDTH*32-1:0]     imem_rdata,
    output logic [FETCH_WIDTH-1:0]        out_valid,
    output logic [FETCH_WIDTH*32-1:0]     out_inst,
    output logic [FETCH_WIDTH*32-1:0]     out_pc,
    input  logic [$clog2(FETCH_WIDTH):0]  deq_count
);
    localparam int FW = FETCH_WIDTH;
    localparam int DW = $clog2(FW) + 1;
    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = $clog2(IQ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     hold_addr_q;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     inst_q [IQ_DEPTH];
    logic [31:0]     pc_q [IQ_DEPTH];
    logic [31:0]     block;
    logic [DW-1:0]   off, deq, enq_n;
    logic [CW-1:0]   free, free_after;
    logic            take;

    always_comb begin
        block      = fetch_pc_q & ~32'(FW * 4 - 1);
        off        = DW'((fetch_pc_q >> 2) & 32'(FW - 1));
        take       = state_q == WAIT && imem_resp && !redirect_valid;
        deq        = redirect_valid ? '0 : deq_count;
        enq_n      = take ? DW'(FW) - off : '0;
        free       = CW'(IQ_DEPTH) - (count_q - CW'(deq));
        free_after = free - CW'(enq_n);
        // While discarding, fetch_pc already holds the redirect target, so the
        // outstanding request's address comes from the captured copy.
        imem_addr  = state_q == DISCARD ? hold_addr_q : block;
        imem_rmask = state_q == IDLE ? 4'h0 : 4'hF;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = redirect_valid ? redirect_pc : take ? block + 32'(FW * 4) : fetch_pc_q;
        head_d     = redirect_valid ? '0 : head_q + PW'(deq);
        tail_d     = redirect_valid ? '0 : tail_q + PW'(enq_n);
        count_d    = redirect_valid ? '0 : count_q - CW'(deq) + CW'(enq_n);
        if (redirect_valid)
            state_d = (state_q == IDLE || imem_resp) ? WAIT : DISCARD;
        else if (state_q == WAIT)
            state_d = !imem_resp ? WAIT : free_after >= CW'(FW) ? WAIT : IDLE;
        else if (state_q == DISCARD)
            state_d = imem_resp ? WAIT : DISCARD;
        else
            state_d = free >= CW'(FW) ? WAIT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            hold_addr_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= state_q == WAIT ? block : hold_addr_q;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            if (!redirect_valid)
                assert (CW'(deq_count) <= count_q && deq_count <= DW'(FW));
        end
    end

    // Surviving slots off..FW-1 land in consecutive entries starting at tail.
    always_ff @(posedge clk) begin
        for (int j = 0; j < FW; j++) begin
            if (DW'(j) < enq_n) begin
                inst_q[tail_q + PW'(j)] <= imem_rdata[32 * ((int'(off) + j) % FW) +: 32];
                pc_q[tail_q + PW'(j)]   <= block + 32'(4 * (int'(off) + j));
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        for (int i = 0; i < FW; i++) begin
            out_valid[i]          = CW'(i) < count_q;
            out_inst[32 * i +: 32] = inst_q[head_q + PW'(i)];
            out_pc[32 * i +: 32]   = pc_q[head_q + PW'(i)];
        end
    end
endmodule

// File: tb/tb_fetch_unit_wide.sv
// tb_fetch_unit_wide: randomized and directed checks of fetch_unit_wide against a queue-based reference model
module tb_fetch_unit_wide;
    localparam int FW = 2;
    localparam int DEPTH = 8;
    localparam int DQW = $clog2(FW) + 1;

    logic              clk = 0;
    logic              rst, redirect_valid, imem_resp;
    logic [31:0]       redirect_pc, imem_addr;
    logic [3:0]        imem_rmask;
    logic [FW*32-1:0]  imem_rdata, out_inst, out_pc;
    logic [FW-1:0]     out_valid;
    logic [DQW-1:0]    deq_count;

    fetch_unit_wide #(.FETCH_WIDTH(FW), .IQ_DEPTH(DEPTH), .RESET_PC(32'h1eceb000)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_resp(imem_resp),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_inst(out_inst),
        .out_pc(out_pc), .deq_count(deq_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;

    int          checks = 0, errors = 0;
    ent_t        iq[$];
    bit          busy, keep;
    logic [31:0] fpc, req_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] blk(input logic [31:0] pc);
        return pc & ~32'(FW * 4 - 1);
    endfunction

    task automatic compare();
        logic [FW-1:0] ev;
        check("rmask", 32'(imem_rmask), busy ? 32'hF : 32'h0);
        if (busy) check("addr", imem_addr, req_addr);
        for (int i = 0; i < FW; i++) ev[i] = i < iq.size();
        check("valid", 32'(out_valid), 32'(ev));
        for (int i = 0; i < FW && i < iq.size(); i++) begin
            check("inst", out_inst[32*i +: 32], iq[i].inst);
            check("pc", out_pc[32*i +: 32], iq[i].pc);
        end
    endtask

    task automatic model_step();
        ent_t e;
        if (redirect_valid) begin
            iq.delete();
            if (busy && !imem_resp) keep = 0;
            else begin busy = 1; keep = 1; req_addr = blk(redirect_pc); end
            fpc = redirect_pc;
        end else begin
            repeat (int'(deq_count)) void'(iq.pop_front());
            if (busy && imem_resp) begin
                if (keep) begin
                    for (int k = int'((fpc >> 2) % FW); k < FW; k++) begin
                        e.inst = imem_rdata[32*k +: 32];
                        e.pc   = blk(fpc) + 32'(4 * k);
                        iq.push_back(e);
                    end
                    fpc = blk(fpc) + 32'(FW * 4);
                end
                busy = 0;
            end
            if (!busy && DEPTH - iq.size() >= FW) begin
                busy = 1; keep = 1; req_addr = blk(fpc);
            end
        end
    endtask

    task automatic cyc(input logic rv, input logic [31:0] rpc, input logic resp, input int dq);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_resp      = resp;
        deq_count      = DQW'(dq);
        for (int i = 0; i < FW; i++) imem_rdata[32*i +: 32] = $urandom;
        #1 compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic int maxdq();
        return iq.size() < FW ? iq.size() : FW;
    endfunction

    initial begin
        logic [31:0] last;
        int blocks;
        rst = 1; redirect_valid = 0; redirect_pc = 0; imem_resp = 0; deq_count = 0; imem_rdata = 0;
        busy = 0; keep = 0; fpc = 32'h1eceb000; req_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("rst_rmask", 32'(imem_rmask), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        cyc(0, 0, 0, 0);
        check("t1_addr", imem_addr, 32'h1eceb000);
        check("t1_rmask", 32'(imem_rmask), 32'hF);
        cyc(0, 0, 1, 0);
        check("t1_valid", 32'(out_valid), 32'h3);
        check("t1_pc0", out_pc[31:0], 32'h1eceb000);
        check("t1_pc1", out_pc[63:32], 32'h1eceb004);

        cyc(1, 32'h1eceb014, 0, 0);
        cyc(0, 0, 1, 0);
        check("rd_addr", imem_addr, 32'h1eceb010);
        check("rd_empty", 32'(out_valid), 32'h0);
        cyc(0, 0, 1, 0);
        check("rd_valid", 32'(out_valid), 32'h1);
        check("rd_pc0", out_pc[31:0], 32'h1eceb014);
        check("rd_next", imem_addr, 32'h1eceb018);

        cyc(1, 32'h1eceb100, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        check("late_empty", 32'(out_valid), 32'h0);
        check("late_addr", imem_addr, 32'h1eceb100);
        cyc(0, 0, 1, 0);
        check("late_pc0", out_pc[31:0], 32'h1eceb100);

        cyc(1, 32'h1eceb208, 1, 0);
        check("same_empty", 32'(out_valid), 32'h0);
        check("same_addr", imem_addr, 32'h1eceb208);
        check("same_rmask", 32'(imem_rmask), 32'hF);

        repeat (6) cyc(0, 0, 1, 0);
        check("full_rmask", 32'(imem_rmask), 32'h0);
        check("full_valid", 32'(out_valid), 32'h3);
        cyc(0, 0, 0, 2);
        check("resume_rmask", 32'(imem_rmask), 32'hF);
        check("resume_addr", imem_addr, 32'h1eceb228);

        cyc(1, 32'h1eceb300, 0, 0);
        last = 32'h1eceb300 - 4;
        blocks = 0;
        for (int n = 0; n < 300 && blocks < 20; n++) begin
            int d;
            d = (n % 2) ? 2 : 1;
            if (d > maxdq()) d = maxdq();
            for (int i = 0; i < d; i++) begin
                check("wrap_seq", out_pc[32*i +: 32], last + 4);
                last = last + 4;
            end
            if (busy && keep) blocks++;
            cyc(0, 0, busy, d);
        end

        for (int n = 0; n < 800; n++) begin
            logic rv;
            rv = $urandom_range(0, 15) == 0;
            cyc(rv, 32'h1eceb000 + ($urandom_range(0, 255) << 2), 1'($urandom_range(0, 1)),
                $urandom_range(0, maxdq()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
